// File: rtl/mul_div_unit.sv
// Multi-cycle signed 32x32 Booth multiplier and 32/32 shift-subtract divider.
// Result is staged into ZHI/ZLO only when an operation completes.
module mul_div_unit #(
    parameter int WIDTH = 32,
    parameter int ITER  = WIDTH
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] z_hi,
    output logic [WIDTH-1:0] z_lo,
    output logic             div_by_zero
);

    localparam int CW = (ITER > 1) ? $clog2(ITER) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIX,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH:0]   acc_q, acc_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic             qm1_q, qm1_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic             op_q, op_d;
    logic             qneg_q, qneg_d;
    logic             rneg_q, rneg_d;
    logic             zero_q, zero_d;
    logic [WIDTH-1:0] zhi_q, zhi_d;
    logic [WIDTH-1:0] zlo_q, zlo_d;
    logic             dbz_q, dbz_d;

    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH:0]   m_ext;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] quot;
    logic [WIDTH-1:0] rem;

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            q_q     <= '0;
            qm1_q   <= 1'b0;
            m_q     <= '0;
            op_q    <= 1'b0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            zero_q  <= 1'b0;
            zhi_q   <= '0;
            zlo_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            q_q     <= q_d;
            qm1_q   <= qm1_d;
            m_q     <= m_d;
            op_q    <= op_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            zero_q  <= zero_d;
            zhi_q   <= zhi_d;
            zlo_q   <= zlo_d;
            dbz_q   <= dbz_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        q_d     = q_q;
        qm1_d   = qm1_q;
        m_d     = m_q;
        op_d    = op_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        zero_d  = zero_q;
        zhi_d   = zhi_q;
        zlo_d   = zlo_q;
        dbz_d   = dbz_q;

        a_neg   = a_in[WIDTH-1];
        b_neg   = b_in[WIDTH-1];
        a_mag   = a_neg ? -a_in : a_in;
        b_mag   = b_neg ? -b_in : b_in;
        m_ext   = {m_q[WIDTH-1], m_q};
        sum     = acc_q;
        shifted = {acc_q[WIDTH-1:0], q_q[WIDTH-1]};
        trial   = shifted - {1'b0, m_q};
        quot    = qneg_q ? -q_q : q_q;
        rem     = rneg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    cnt_d  = '0;
                    op_d   = op;
                    dbz_d  = 1'b0;
                    acc_d  = '0;
                    qm1_d  = 1'b0;
                    zero_d = 1'b0;
                    if (op && (b_in == '0)) begin
                        // Keep the raw dividend; it becomes the remainder
                        zero_d  = 1'b1;
                        q_d     = a_in;
                        state_d = S_FIX;
                    end else if (op) begin
                        q_d     = a_mag;
                        m_d     = b_mag;
                        qneg_d  = a_neg ^ b_neg;
                        rneg_d  = a_neg;
                        state_d = S_RUN;
                    end else begin
                        q_d     = b_in;
                        m_d     = a_in;
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                cnt_d = cnt_q + 1'b1;
                if (op_q) begin
                    if (!trial[WIDTH]) begin
                        acc_d = trial;
                        q_d   = {q_q[WIDTH-2:0], 1'b1};
                    end else begin
                        acc_d = shifted;
                        q_d   = {q_q[WIDTH-2:0], 1'b0};
                    end
                end else begin
                    unique case ({q_q[0], qm1_q})
                        2'b01:   sum = acc_q + m_ext;
                        2'b10:   sum = acc_q - m_ext;
                        default: sum = acc_q;
                    endcase
                    acc_d = {sum[WIDTH], sum[WIDTH:1]};
                    q_d   = {sum[0], q_q[WIDTH-1:1]};
                    qm1_d = q_q[0];
                end
                if (cnt_q == CW'(ITER - 1)) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                if (zero_q && (cnt_q == '0)) begin
                    // Pad so divide-by-zero still takes two edges to DONE
                    cnt_d = cnt_q + 1'b1;
                end else begin
                    cnt_d   = '0;
                    state_d = S_DONE;
                    if (zero_q) begin
                        zhi_d = q_q;
                        zlo_d = '1;
                        dbz_d = 1'b1;
                    end else if (op_q) begin
                        zhi_d = rem;
                        zlo_d = quot;
                    end else begin
                        zhi_d = acc_q[WIDTH-1:0];
                        zlo_d = q_q;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy        = (state_q == S_RUN) || (state_q == S_FIX);
    assign done        = (state_q == S_DONE);
    assign z_hi        = zhi_q;
    assign z_lo        = zlo_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: results, latency, hold, ignore and abort.
module tb_mul_div_unit;

    logic        clock;
    logic        clear;
    logic        start;
    logic        op;
    logic [31:0] a_in;
    logic [31:0] b_in;
    logic        busy;
    logic        done;
    logic [31:0] z_hi;
    logic [31:0] z_lo;
    logic        div_by_zero;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
        int          lat;
    } exp_t;

    exp_t        sb[$];
    int          vec_cnt = 0;
    int          err_cnt = 0;
    logic [31:0] prev_hi = '0;
    logic [31:0] prev_lo = '0;

    mul_div_unit #(.WIDTH(32), .ITER(32)) dut (
        .clock       (clock),
        .clear       (clear),
        .start       (start),
        .op          (op),
        .a_in        (a_in),
        .b_in        (b_in),
        .busy        (busy),
        .done        (done),
        .z_hi        (z_hi),
        .z_lo        (z_lo),
        .div_by_zero (div_by_zero)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic o, input logic [31:0] a,
                                   input logic [31:0] b);
        exp_t   e;
        longint sa, sb_, p, q, r;
        sa = longint'($signed(a));
        sb_ = longint'($signed(b));
        e.dbz = 1'b0;
        e.lat = 33;
        if (!o) begin
            p = sa * sb_;
            e.hi = p[63:32];
            e.lo = p[31:0];
        end else if (b == 32'd0) begin
            e.hi = a;
            e.lo = 32'hFFFF_FFFF;
            e.dbz = 1'b1;
            e.lat = 2;
        end else begin
            q = sa / sb_;
            r = sa % sb_;
            e.hi = r[31:0];
            e.lo = q[31:0];
        end
        return e;
    endfunction

    task automatic run_op(input logic o, input logic [31:0] a,
                          input logic [31:0] b, input int inj_at,
                          input int clr_at);
        exp_t e;
        int   n;
        bit   got;
        sb.push_back(model(o, a, b));
        @(negedge clock);
        check("done_low", 64'(done), 64'd0);
        start = 1'b1;
        op    = o;
        a_in  = a;
        b_in  = b;
        @(posedge clock);
        n = 0;
        @(negedge clock);
        start = 1'b0;
        op    = ~o;
        a_in  = $urandom;
        b_in  = $urandom;
        check("busy_e0", 64'(busy), 64'd1);
        check("dbz_clr", 64'(div_by_zero), 64'd0);
        got = 0;
        while (!got && n < 40) begin
            if (n == clr_at) begin
                #1 clear = 1'b1;
                #1;
                check("clr_out", {busy, done, div_by_zero, z_hi, z_lo},
                      67'd0);
                @(negedge clock);
                clear = 1'b0;
                void'(sb.pop_back());
                prev_hi = '0;
                prev_lo = '0;
                return;
            end
            if (n == inj_at - 1) begin
                start = 1'b1;
                op    = $urandom;
                a_in  = $urandom;
                b_in  = $urandom;
            end else begin
                start = 1'b0;
            end
            @(posedge clock);
            n++;
            @(negedge clock);
            if (done) begin
                got = 1;
            end else begin
                check("hold", {z_hi, z_lo}, {prev_hi, prev_lo});
            end
        end
        start = 1'b0;
        e = sb.pop_front();
        if (!got) begin
            check("timeout", 64'd0, 64'd1);
        end else begin
            check("latency", 64'(n), 64'(e.lat));
            check("z_hi", 64'(z_hi), 64'(e.hi));
            check("z_lo", 64'(z_lo), 64'(e.lo));
            check("dbz", 64'(div_by_zero), 64'(e.dbz));
            check("busy_done", 64'(busy), 64'd0);
            prev_hi = e.hi;
            prev_lo = e.lo;
        end
    endtask

    initial begin
        clear = 1'b1;
        start = 1'b0;
        op    = 1'b0;
        a_in  = '0;
        b_in  = '0;
        #2;
        check("rst_out", {busy, done, div_by_zero, z_hi, z_lo}, 67'd0);
        @(negedge clock);
        clear = 1'b0;

        run_op(1'b0, 32'd7, 32'hFFFF_FFFD, -1, -1);
        run_op(1'b0, 32'h8000_0000, 32'h8000_0000, -1, -1);
        run_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, -1);
        run_op(1'b1, 32'hFFFF_FFEF, 32'd5, -1, -1);
        run_op(1'b1, 32'd17, 32'hFFFF_FFFB, -1, -1);
        run_op(1'b1, 32'd100, 32'd0, -1, -1);
        run_op(1'b1, 32'd1000, 32'd7, -1, -1);
        run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, -1, -1);
        run_op(1'b0, 32'd12345, 32'hFFFF_FD5A, 5, -1);
        run_op(1'b0, 32'hDEAD_BEEF, 32'h1234_5678, -1, 10);
        run_op(1'b0, 32'h0001_0000, 32'h0000_FFFF, -1, -1);
        for (int i = 0; i < 8; i++) begin
            run_op(1'(i), $urandom, (i == 5) ? 32'd0 : $urandom, -1, -1);
        end
        @(negedge clock);
        check("done_end", 64'(done), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vec_cnt, err_cnt);
        $finish;
    end

endmodule
